pool_window_feeder: RTL and testbench

Streams a raster-order feature map into 2x2 pooling windows for the max-pool accelerator. Buffers two rows of the map, then emits each window's four values on consecutive beats with a first-of-window marker, so the downstream pooling unit sees exactly four valid beats per window. Sits between the HPS/DMA pixel stream and the pooling accelerator in the CNN acceleration path.

---
 rtl/pool_pkg.sv | 19 +
 rtl/pool_line_buffer.sv | 28 ++
 rtl/pool_window_feeder.sv | 170 +++++++++++++++++
 tb/tb_pool_window_feeder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared types and constants for the 2x2 max-pool window feeder.
package pool_pkg;

    localparam int POOL_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } feeder_state_t;

    // Beat order inside one window: top row left/right, then bottom row left/right.
    localparam logic [1:0] BEAT_R0C0 = 2'd0;
    localparam logic [1:0] BEAT_R0C1 = 2'd1;
    localparam logic [1:0] BEAT_R1C0 = 2'd2;
    localparam logic [1:0] BEAT_R1C1 = 2'd3;

endpackage

// File: rtl/pool_line_buffer.sv
// Two-row line buffer: one write port, one combinational read port, both addressed by {row, col}.
module pool_line_buffer #(
    parameter int DATA_W = 32,
    parameter int MAP_W  = 8,
    parameter int COL_W  = $clog2(MAP_W)
) (
    input  logic              clk,
    input  logic              i_wrEn,
    input  logic              i_wrRow,
    input  logic [COL_W-1:0]  i_wrCol,
    input  logic [DATA_W-1:0] i_wrData,
    input  logic              i_rdRow,
    input  logic [COL_W-1:0]  i_rdCol,
    output logic [DATA_W-1:0] o_rdData
);

    // Row stride is a power of two so {row, col} is a plain concatenation.
    logic [DATA_W-1:0] r_mem [2**(COL_W+1)];

    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[{i_wrRow, i_wrCol}] <= i_wrData;
        end
    end

    assign o_rdData = r_mem[{i_rdRow, i_rdCol}];

endmodule

// File: rtl/pool_window_feeder.sv
// Buffers two raster rows and emits 2x2 pooling windows as four beats with a first-of-window flag.
// Optional build macro POOL_FEEDER_RELU_EN clamps negative pixels to zero as they are buffered.
module pool_window_feeder
    import pool_pkg::*;
#(
    parameter int DATA_W = POOL_DATA_W,
    parameter int MAP_W  = 8,
    parameter int MAP_H  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_first,
    output logic              busy,
    output logic              done
);

    localparam int COL_W = $clog2(MAP_W);
    localparam int CIW   = $clog2(2 * MAP_W);
    localparam int RPW   = $clog2(MAP_H / 2 + 1);

    localparam logic [CIW-1:0] LAST_FILL    = CIW'(2 * MAP_W - 1);
    localparam logic [CIW-1:0] LAST_PAIR    = CIW'(MAP_W - 2);
    localparam logic [RPW-1:0] LAST_ROWPAIR = RPW'(MAP_H / 2 - 1);

    feeder_state_t     r_state;
    logic [CIW-1:0]    r_colIdx;
    logic [1:0]        r_beat;
    logic [RPW-1:0]    r_rowPair;
    logic              r_inReady;
    logic              r_outValid;
    logic              r_outFirst;
    logic [DATA_W-1:0] r_outData;
    logic              r_busy;
    logic              r_done;

    logic              w_inAccept;
    logic              w_outAccept;
    logic              w_wrRow;
    logic [COL_W-1:0]  w_wrCol;
    logic [DATA_W-1:0] w_wrData;
    logic [1:0]        w_ldBeat;
    logic [CIW-1:0]    w_ldCol;
    logic              w_rdRow;
    logic [COL_W-1:0]  w_rdCol;
    logic [DATA_W-1:0] w_rdData;

    assign w_inAccept  = r_inReady & in_valid;
    assign w_outAccept = r_outValid & out_ready;

    // During FILL the column index is the raster position inside the row pair.
    assign w_wrRow = (r_colIdx >= CIW'(MAP_W));
    assign w_wrCol = COL_W'(w_wrRow ? (r_colIdx - CIW'(MAP_W)) : r_colIdx);

`ifdef POOL_FEEDER_RELU_EN
    assign w_wrData = in_data[DATA_W-1] ? '0 : in_data;
`else
    assign w_wrData = in_data;
`endif

    // Address of the beat to load into the output register at the next accepting edge.
    assign w_ldBeat = (r_state == EMIT) ? r_beat + 2'd1 : BEAT_R0C0;
    assign w_ldCol  = (r_state != EMIT)        ? '0 :
                      (r_beat == BEAT_R1C1)    ? r_colIdx + CIW'(2) : r_colIdx;
    assign w_rdRow  = w_ldBeat[1];
    assign w_rdCol  = COL_W'(w_ldCol + CIW'(w_ldBeat[0]));

    pool_line_buffer #(
        .DATA_W (DATA_W),
        .MAP_W  (MAP_W),
        .COL_W  (COL_W)
    ) u_lineBuffer (
        .clk      (clk),
        .i_wrEn   (w_inAccept),
        .i_wrRow  (w_wrRow),
        .i_wrCol  (w_wrCol),
        .i_wrData (w_wrData),
        .i_rdRow  (w_rdRow),
        .i_rdCol  (w_rdCol),
        .o_rdData (w_rdData)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_colIdx   <= '0;
            r_beat     <= BEAT_R0C0;
            r_rowPair  <= '0;
            r_inReady  <= 1'b0;
            r_outValid <= 1'b0;
            r_outFirst <= 1'b0;
            r_outData  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state   <= FILL;
                        r_inReady <= 1'b1;
                        r_busy    <= 1'b1;
                        r_colIdx  <= '0;
                        r_beat    <= BEAT_R0C0;
                        r_rowPair <= '0;
                    end
                end
                FILL: begin
                    if (w_inAccept) begin
                        if (r_colIdx == LAST_FILL) begin
                            r_state    <= EMIT;
                            r_inReady  <= 1'b0;
                            r_outValid <= 1'b1;
                            r_outFirst <= 1'b1;
                            r_outData  <= w_rdData;
                            r_colIdx   <= '0;
                            r_beat     <= BEAT_R0C0;
                        end else begin
                            r_colIdx <= r_colIdx + CIW'(1);
                        end
                    end
                end
                EMIT: begin
                    if (w_outAccept) begin
                        if (r_beat == BEAT_R1C1 && r_colIdx == LAST_PAIR) begin
                            r_outValid <= 1'b0;
                            r_outFirst <= 1'b0;
                            r_colIdx   <= '0;
                            r_beat     <= BEAT_R0C0;
                            r_rowPair  <= r_rowPair + RPW'(1);
                            if (r_rowPair == LAST_ROWPAIR) begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state   <= FILL;
                                r_inReady <= 1'b1;
                            end
                        end else begin
                            r_outData  <= w_rdData;
                            r_outFirst <= (w_ldBeat == BEAT_R0C0);
                            r_beat     <= w_ldBeat;
                            r_colIdx   <= w_ldCol;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_inReady;
    assign out_valid = r_outValid;
    assign out_first = r_outFirst;
    assign out_data  = r_outData;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_pool_window_feeder.sv
// Self-checking bench for pool_window_feeder on a 4x4 map against a window-order reference model.
`timescale 1ns/1ps
module tb_pool_window_feeder;

    localparam int DW     = 32;
    localparam int MW     = 4;
    localparam int MH     = 4;
    localparam int NPIX   = MW * MH;
    localparam int BUDGET = 2000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_first;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] pix [NPIX];
    logic [DW-1:0] expData [$];
    logic          expFirst [$];

    always #5 clk = ~clk;

    pool_window_feeder #(
        .DATA_W (DW),
        .MAP_W  (MW),
        .MAP_H  (MH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_first (out_first),
        .busy      (busy),
        .done      (done)
    );

    function automatic logic [DW-1:0] storedValue(input logic [DW-1:0] v);
`ifdef POOL_FEEDER_RELU_EN
        return ($signed(v) < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_in_ready"}, in_ready, 0);
        checkOutput({tag, "_out_valid"}, out_valid, 0);
        checkOutput({tag, "_out_data"}, out_data, 0);
        checkOutput({tag, "_out_first"}, out_first, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
    endtask

    // Expected beats: every row pair, every column pair, four pixels of the 2x2 window.
    task automatic buildModel();
        expData.delete();
        expFirst.delete();
        for (int rp = 0; rp < MH / 2; rp++) begin
            for (int c = 0; c < MW / 2; c++) begin
                for (int b = 0; b < 4; b++) begin
                    expData.push_back(storedValue(pix[(2 * rp + b / 2) * MW + 2 * c + b % 2]));
                    expFirst.push_back(b == 0);
                end
            end
        end
    endtask

    // mode 0: streams held open; mode 1: out_ready toggles 1,0; mode 2: random handshakes.
    task automatic applyStimulus(input int mode, input int abortAfter, input bit pokeStart);
        int pixPtr = 0;
        int beatCnt = 0;
        int cyc = 0;
        bit mFill, mEmit, mDone, mBusy;
        bit nFill, nEmit, nDone, nBusy;
        buildModel();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mFill = 1'b1;
        mEmit = 1'b0;
        mDone = 1'b0;
        mBusy = 1'b1;
        while (cyc < BUDGET) begin
            checkOutput("in_ready", in_ready, mFill);
            checkOutput("out_valid", out_valid, mEmit);
            checkOutput("done", done, mDone);
            checkOutput("busy", busy, mBusy);
            if (mEmit && expData.size() > 0) begin
                checkOutput("out_data", out_data, expData[0]);
                checkOutput("out_first", out_first, expFirst[0]);
            end
            if (!mBusy) break;
            if (abortAfter > 0 && pixPtr == abortAfter) begin
                reset = 1'b1;
                #1;
                checkResetState("abort");
                @(negedge clk);
                reset = 1'b0;
                @(negedge clk);
                checkResetState("abort_released");
                in_valid = 1'b0;
                out_ready = 1'b0;
                return;
            end
            in_valid  = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            in_data   = (pixPtr < NPIX) ? pix[pixPtr] : $urandom();
            out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
            start     = pokeStart && ($urandom_range(0, 3) == 0);
            nFill = mFill;
            nEmit = mEmit;
            nDone = 1'b0;
            nBusy = mBusy && !mDone;
            if (mFill && in_valid) begin
                pixPtr++;
                if (pixPtr % (2 * MW) == 0) begin
                    nFill = 1'b0;
                    nEmit = 1'b1;
                end
            end
            if (mEmit && out_ready) begin
                void'(expData.pop_front());
                void'(expFirst.pop_front());
                beatCnt++;
                if (beatCnt % (2 * MW) == 0) begin
                    nEmit = 1'b0;
                    if (beatCnt == NPIX) nDone = 1'b1;
                    else nFill = 1'b1;
                end
            end
            mFill = nFill;
            mEmit = nEmit;
            mDone = nDone;
            mBusy = nBusy;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        checkOutput("cycle_budget", cyc < BUDGET, 1);
        checkOutput("beats_left", expData.size(), 0);
        checkOutput("pixels_used", pixPtr, NPIX);
        checkOutput("beats_seen", beatCnt, NPIX);
    endtask

    initial begin
        $display("[TB] pool_window_feeder %0dx%0d map", MW, MH);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkResetState("por");
        reset = 1'b0;
        @(negedge clk);
        checkResetState("idle");

        for (int i = 0; i < NPIX; i++) pix[i] = DW'(i + 1);
        applyStimulus(0, 0, 1'b0);

        applyStimulus(1, 0, 1'b1);

        for (int i = 0; i < NPIX; i++) pix[i] = $urandom();
        pix[0] = DW'(-3);
        pix[1] = DW'(7);
        pix[MW] = DW'(-1);
        pix[MW + 1] = DW'(0);
        applyStimulus(0, 0, 1'b0);

        for (int i = 0; i < NPIX; i++) pix[i] = DW'(i + 1);
        applyStimulus(2, 5, 1'b0);
        applyStimulus(0, 0, 1'b0);

        repeat (3) begin
            for (int i = 0; i < NPIX; i++) pix[i] = $urandom();
            applyStimulus(2, 0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
